// File: rtl/iram_port_if.sv
// Bundle of requester, status and iRAM port signals for iram_port_arbiter.
// slave = arbiter side, master = requesters plus the RAM itself.
interface iram_port_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 24
);
  logic              cpu_paused;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ack;
  logic              wr_blocked;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_valid;
  logic              verify_err;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_paused, fetch_req, fetch_addr, ld_we, ld_addr, ld_data,
           dbg_req, dbg_addr, ram_rdata,
    output fetch_data, fetch_valid, ld_ack, wr_blocked, dbg_data, dbg_valid,
           verify_err, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output cpu_paused, fetch_req, fetch_addr, ld_we, ld_addr, ld_data,
           dbg_req, dbg_addr, ram_rdata,
    input  fetch_data, fetch_valid, ld_ack, wr_blocked, dbg_data, dbg_valid,
           verify_err, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/iram_port_arbiter.sv
// Single-port iRAM arbiter: loader write > CPU fetch > debug read, with debug anti-starvation.
// Define IRAM_WRITE_VERIFY_EN to add read-back verification with retries on loader writes.
module iram_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 24,
  parameter int DBG_MAX_WAIT = 4
`ifdef IRAM_WRITE_VERIFY_EN
  ,
  parameter int VERIFY_RETRIES = 2
`endif
) (
  input logic        clk,
  input logic        rst_n,
  iram_port_if.slave bus
);

  localparam int WAIT_W = $clog2(DBG_MAX_WAIT + 1);

  typedef enum logic [3:0] {
    IDLE, FETCH_RD, FETCH_CAP, DBG_RD, DBG_CAP, WRITE, VERIFY_RD, VERIFY_CMP, ACK_WAIT
  } state_e;

  state_e state_q, state_d;

  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
  logic              dbg_valid_q, dbg_valid_d;
  logic              ld_ack_q, ld_ack_d;
  logic              wr_blocked_q, wr_blocked_d;
  logic [WAIT_W-1:0] dbg_wait_q, dbg_wait_d;
  logic              dbg_starved;
  logic              grant;

`ifdef IRAM_WRITE_VERIFY_EN
  localparam int RETRY_W = (VERIFY_RETRIES > 0) ? $clog2(VERIFY_RETRIES + 1) : 1;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               verify_err_q, verify_err_d;
  logic               verify_ok;
  // ram_wdata_q still holds the word latched at grant, so it is the reference.
  assign verify_ok = (bus.ram_rdata == ram_wdata_q);
`endif

  assign dbg_starved = (dbg_wait_q >= WAIT_W'(DBG_MAX_WAIT));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.dbg_req && dbg_starved)            state_d = DBG_RD;
        else if (bus.ld_we && bus.cpu_paused)      state_d = WRITE;
        else if (bus.fetch_req && !bus.cpu_paused) state_d = FETCH_RD;
        else if (bus.dbg_req)                      state_d = DBG_RD;
      end
      FETCH_RD:   state_d = FETCH_CAP;
      FETCH_CAP:  state_d = IDLE;
      DBG_RD:     state_d = DBG_CAP;
      DBG_CAP:    state_d = IDLE;
`ifdef IRAM_WRITE_VERIFY_EN
      WRITE:      state_d = VERIFY_RD;
      VERIFY_RD:  state_d = VERIFY_CMP;
      VERIFY_CMP: state_d = (verify_ok || retry_q == RETRY_W'(VERIFY_RETRIES)) ? ACK_WAIT : WRITE;
`else
      WRITE:      state_d = ACK_WAIT;
`endif
      // Hold here until the loader drops its enable so one request is one write.
      ACK_WAIT:   if (!bus.ld_we) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    grant         = (state_q == IDLE) && (state_d != IDLE);
    ram_en_d      = state_d inside {FETCH_RD, DBG_RD, WRITE, VERIFY_RD};
    ram_we_d      = (state_d == WRITE);
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    if (grant) begin
      case (state_d)
        FETCH_RD: ram_addr_d = bus.fetch_addr;
        DBG_RD:   ram_addr_d = bus.dbg_addr;
        WRITE: begin
          ram_addr_d  = bus.ld_addr;
          ram_wdata_d = bus.ld_data;
        end
        default: ;
      endcase
    end
    fetch_valid_d = (state_q == FETCH_CAP);
    fetch_data_d  = (state_q == FETCH_CAP) ? bus.ram_rdata : fetch_data_q;
    dbg_valid_d   = (state_q == DBG_CAP);
    dbg_data_d    = (state_q == DBG_CAP) ? bus.ram_rdata : dbg_data_q;
    ld_ack_d      = (state_d == ACK_WAIT) && (state_q != ACK_WAIT);
    wr_blocked_d  = bus.ld_we && !bus.cpu_paused;
    // A losing debug request can never be starved already, so no saturation check is needed.
    dbg_wait_d    = dbg_wait_q;
    if (grant && state_d == DBG_RD)   dbg_wait_d = '0;
    else if (grant && bus.dbg_req)    dbg_wait_d = dbg_wait_q + WAIT_W'(1);
`ifdef IRAM_WRITE_VERIFY_EN
    retry_d = retry_q;
    if (grant && state_d == WRITE)                       retry_d = '0;
    else if (state_q == VERIFY_CMP && state_d == WRITE)  retry_d = retry_q + RETRY_W'(1);
    verify_err_d = verify_err_q ||
                   (state_q == VERIFY_CMP && !verify_ok && state_d == ACK_WAIT);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      fetch_data_q  <= '0;
      fetch_valid_q <= 1'b0;
      dbg_data_q    <= '0;
      dbg_valid_q   <= 1'b0;
      ld_ack_q      <= 1'b0;
      wr_blocked_q  <= 1'b0;
      dbg_wait_q    <= '0;
`ifdef IRAM_WRITE_VERIFY_EN
      retry_q       <= '0;
      verify_err_q  <= 1'b0;
`endif
    end else begin
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_valid_d;
      dbg_data_q    <= dbg_data_d;
      dbg_valid_q   <= dbg_valid_d;
      ld_ack_q      <= ld_ack_d;
      wr_blocked_q  <= wr_blocked_d;
      dbg_wait_q    <= dbg_wait_d;
`ifdef IRAM_WRITE_VERIFY_EN
      retry_q       <= retry_d;
      verify_err_q  <= verify_err_d;
`endif
    end
  end

  assign bus.ram_en      = ram_en_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.fetch_data  = fetch_data_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.dbg_data    = dbg_data_q;
  assign bus.dbg_valid   = dbg_valid_q;
  assign bus.ld_ack      = ld_ack_q;
  assign bus.wr_blocked  = wr_blocked_q;
`ifdef IRAM_WRITE_VERIFY_EN
  assign bus.verify_err  = verify_err_q;
`else
  assign bus.verify_err  = 1'b0;
`endif

endmodule

// File: tb/tb_iram_port_arbiter.sv
// Directed bench for iram_port_arbiter with a behavioural 1-cycle-latency iRAM.
// Covers reset, fetch, debug read, loader write, blocked write, starvation and (IRAM_WRITE_VERIFY_EN) verify.
module tb_iram_port_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 24;
`ifdef IRAM_WRITE_VERIFY_EN
  localparam int ACK_LAT = 4;
`else
  localparam int ACK_LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  iram_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  iram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // iRAM model: preloaded during reset, optional bit-0 corruption on writes
  logic [DATA_W-1:0] mem [256];
  logic corrupt;
  int   we_cnt;
  int   ack_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem[8'h00] <= 24'h000000;
      mem[8'h05] <= 24'hA1B2C3;
      mem[8'h20] <= 24'h5A5A01;
      mem[8'h21] <= 24'h5A5A02;
      we_cnt     <= 0;
      ack_cnt    <= 0;
    end else begin
      if (bus.ram_en && bus.ram_we) begin
        mem[bus.ram_addr] <= corrupt ? (bus.ram_wdata ^ 24'h000001) : bus.ram_wdata;
        we_cnt <= we_cnt + 1;
      end
      if (bus.ld_ack) ack_cnt <= ack_cnt + 1;
    end
    if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

  int w0, a0, ack_at, fg, dg_at, dv_at;
  logic [DATA_W-1:0] dv_data;
  logic got, err_at_ack;

  initial begin
    rst_n          = 1'b0;
    corrupt        = 1'b0;
    bus.cpu_paused = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = '0;
    bus.ld_we      = 1'b1;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    bus.dbg_req    = 1'b1;
    bus.dbg_addr   = '0;
    err_at_ack     = 1'b0;
    dv_data        = '0;

    // Reset with every request asserted
    tick(); tick(); tick();
    check("rst_flags", 32'({bus.ram_en, bus.ram_we, bus.fetch_valid, bus.dbg_valid,
                            bus.ld_ack, bus.wr_blocked, bus.verify_err}), 0);
    check("rst_ram_addr", 32'(bus.ram_addr), 0);
    check("rst_ram_wdata", 32'(bus.ram_wdata), 0);
    check("rst_fetch_data", 32'(bus.fetch_data), 0);
    check("rst_dbg_data", 32'(bus.dbg_data), 0);
    rst_n = 1'b1;
    check("rel_ram_en_same_cycle", 32'(bus.ram_en), 0);
    tick();
    check("rel_ram_en_next", 32'(bus.ram_en), 1);
    check("rel_wr_blocked", 32'(bus.wr_blocked), 1);
    bus.fetch_req = 1'b0;
    bus.ld_we     = 1'b0;
    bus.dbg_req   = 1'b0;
    tick(); tick(); tick(); tick();

    // Lone debug read (also clears the wait count left by the reset release)
    bus.dbg_addr = 8'h20;
    bus.dbg_req  = 1'b1;
    tick();
    check("dbg_ram_en", 32'({bus.ram_en, bus.ram_we}), 32'b10);
    check("dbg_ram_addr", 32'(bus.ram_addr), 32'h20);
    tick(); tick();
    check("dbg_valid", 32'(bus.dbg_valid), 1);
    check("dbg_data", 32'(bus.dbg_data), 32'h5A5A01);
    bus.dbg_req = 1'b0;
    tick();

    // CPU fetch from 0x05
    bus.fetch_addr = 8'h05;
    bus.fetch_req  = 1'b1;
    tick();
    check("fetch_ram_en_we", 32'({bus.ram_en, bus.ram_we}), 32'b10);
    check("fetch_ram_addr", 32'(bus.ram_addr), 32'h05);
    tick();
    check("fetch_valid_early", 32'(bus.fetch_valid), 0);
    tick();
    check("fetch_valid", 32'(bus.fetch_valid), 1);
    check("fetch_data", 32'(bus.fetch_data), 32'hA1B2C3);
    bus.fetch_req = 1'b0;
    tick();
    check("fetch_no_regrant", 32'({bus.ram_en, bus.fetch_valid}), 0);

    // Loader write, enable held 4 cycles
    bus.cpu_paused = 1'b1;
    bus.ld_addr    = 8'h10;
    bus.ld_data    = 24'h123456;
    bus.ld_we      = 1'b1;
    w0 = we_cnt; a0 = ack_cnt; ack_at = -1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 1) begin
        check("wr_ram_we", 32'({bus.ram_en, bus.ram_we}), 32'b11);
        check("wr_ram_addr_data", {bus.ram_addr, bus.ram_wdata}, 32'h10123456);
      end
      if (bus.ld_ack && ack_at < 0) ack_at = i;
      if (i == 4) bus.ld_we = 1'b0;
    end
    check("wr_ack_latency", ack_at, ACK_LAT);
    check("wr_single_pulse", we_cnt - w0, 1);
    check("wr_single_ack", ack_cnt - a0, 1);
    check("wr_mem_10", 32'(mem[8'h10]), 32'h123456);

    // Write held off while the CPU runs, then released by pausing
    bus.cpu_paused = 1'b0;
    bus.ld_addr    = 8'h11;
    bus.ld_data    = 24'h00BEEF;
    bus.ld_we      = 1'b1;
    w0 = we_cnt;
    tick();
    check("blk_wr_blocked", 32'(bus.wr_blocked), 1);
    tick(); tick(); tick();
    check("blk_no_write", we_cnt - w0, 0);
    check("blk_still_blocked", 32'(bus.wr_blocked), 1);
    bus.cpu_paused = 1'b1;
    tick();
    check("blk_release_we", 32'({bus.ram_we, bus.wr_blocked}), 32'b10);
    check("blk_release_addr", 32'(bus.ram_addr), 32'h11);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (bus.ld_ack) got = 1'b1;
    end
    bus.ld_we = 1'b0;
    tick(); tick();
    check("blk_acked", 32'(got), 1);
    check("blk_mem_11", 32'(mem[8'h11]), 32'h00BEEF);
    bus.cpu_paused = 1'b0;
    tick();

    // Debug starvation under continuous fetch
    bus.fetch_addr = 8'h05;
    bus.dbg_addr   = 8'h21;
    bus.fetch_req  = 1'b1;
    bus.dbg_req    = 1'b1;
    fg = 0; dg_at = -1; dv_at = -1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (bus.ram_en && !bus.ram_we && dg_at < 0) begin
        if (bus.ram_addr == 8'h21) dg_at = i;
        else if (bus.ram_addr == 8'h05) fg++;
      end
      if (bus.dbg_valid && dv_at < 0) begin
        dv_at   = i;
        dv_data = bus.dbg_data;
        bus.dbg_req = 1'b0;
      end
    end
    bus.fetch_req = 1'b0;
    tick(); tick(); tick(); tick();
    check("starve_lost_arbs", fg, 4);
    check("starve_grant_cycle", dg_at, 13);
    check("starve_valid_cycle", dv_at, 15);
    check("starve_dbg_data", 32'(dv_data), 32'h5A5A02);

`ifdef IRAM_WRITE_VERIFY_EN
    // Every write corrupted: two retries, then ack with verify_err
    corrupt        = 1'b1;
    bus.cpu_paused = 1'b1;
    bus.ld_addr    = 8'h30;
    bus.ld_data    = 24'h0F0F0E;
    bus.ld_we      = 1'b1;
    w0 = we_cnt; ack_at = -1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (bus.ld_ack && ack_at < 0) begin
        ack_at     = i;
        err_at_ack = bus.verify_err;
        bus.ld_we  = 1'b0;
      end
    end
    bus.ld_we = 1'b0;
    check("ver_write_pulses", we_cnt - w0, 3);
    check("ver_ack_cycle", ack_at, 10);
    check("ver_err_with_ack", 32'(err_at_ack), 1);
    corrupt     = 1'b0;
    bus.ld_addr = 8'h31;
    bus.ld_data = 24'h654321;
    bus.ld_we   = 1'b1;
    ack_at = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.ld_ack && ack_at < 0) begin
        ack_at    = i;
        bus.ld_we = 1'b0;
      end
    end
    bus.ld_we = 1'b0;
    check("ver_clean_ack", ack_at, 4);
    check("ver_err_sticky", 32'(bus.verify_err), 1);
    check("ver_mem_31", 32'(mem[8'h31]), 32'h654321);
`else
    check("verify_err_tied", 32'(bus.verify_err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
